// File: rtl/Structures.sv
// Shared types for the UART-attached register blocks: packet beat, write
// controller state encoding and the default destination id.
package Structures;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        DISCARD,
        ACK
    } wr_state_e;

    localparam logic [7:0] WRITE_DEST_DEFAULT = 8'h01;

endpackage

// File: rtl/write_controller.sv
// Turns a UART packet (address byte + DATA_LENGTH data bytes, MSB first) into a
// single-cycle register write. Define WRITE_CONTROLLER_ACK_EN to send an ack packet.
module write_controller
    import Structures::*;
#(
    parameter int         DATA_LENGTH = 4,
    parameter logic [7:0] WRITE_DEST  = WRITE_DEST_DEFAULT
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  UART_PACKET  ipRxStream,
    input  logic        ipTxReady,
    output UART_PACKET  opTxStream,
    output logic [7:0]  opWrAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable
);

    localparam int CNT_W = ($clog2(DATA_LENGTH + 1) > 3) ? $clog2(DATA_LENGTH + 1) : 3;

    wr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       src_q, src_d;
    logic             pend_q, pend_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic        rx_start;
    logic        rx_eop;
    logic [31:0] data_shift;
    logic        unused_ok;

    assign rx_start   = ipRxStream.Valid && ipRxStream.SoP && (ipRxStream.Destination == WRITE_DEST);
    assign rx_eop     = ipRxStream.Valid && ipRxStream.EoP;
    assign data_shift = {data_q[23:0], ipRxStream.Data};
    assign unused_ok  = ^{ipRxStream.Length, ipTxReady, src_q};

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            src_q     <= '0;
            pend_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            src_q     <= src_d;
            pend_q    <= pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        src_d     = src_q;
        pend_d    = pend_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                // A one-beat packet ends before any data, so it is never started.
                if (rx_start && !ipRxStream.EoP) begin
                    state_d = GET_DATA;
                    addr_d  = ipRxStream.Data;
                    src_d   = ipRxStream.Source;
                    cnt_d   = CNT_W'(DATA_LENGTH);
                    data_d  = '0;
                end
            end
            GET_DATA: begin
                if (rx_start) begin
                    addr_d  = ipRxStream.Data;
                    src_d   = ipRxStream.Source;
                    cnt_d   = CNT_W'(DATA_LENGTH);
                    data_d  = '0;
                    if (ipRxStream.EoP) state_d = IDLE;
                end else if (ipRxStream.Valid) begin
                    data_d = data_shift;
                    if (cnt_q == CNT_W'(1)) begin
                        wr_addr_d = addr_q;
                        wr_data_d = data_shift;
                        pend_d    = !ipRxStream.EoP;
                        state_d   = WRITE;
                    end else if (ipRxStream.EoP) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                // Trailing beats may already arrive during the strobe cycle.
                pend_d = pend_q && !rx_eop;
`ifdef WRITE_CONTROLLER_ACK_EN
                state_d = ACK;
`else
                state_d = pend_d ? DISCARD : IDLE;
`endif
            end
            DISCARD: begin
                if (rx_eop) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            end
`ifdef WRITE_CONTROLLER_ACK_EN
            ACK: begin
                if (ipTxReady) state_d = pend_q ? DISCARD : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign opWrEnable  = (state_q == WRITE);
    assign opWrAddress = wr_addr_q;
    assign opWrData    = wr_data_q;

`ifdef WRITE_CONTROLLER_ACK_EN
    always_comb begin
        opTxStream = '0;
        if (state_q == ACK) begin
            opTxStream.Valid       = 1'b1;
            opTxStream.SoP         = 1'b1;
            opTxStream.EoP         = 1'b1;
            opTxStream.Length      = 8'd1;
            opTxStream.Source      = WRITE_DEST;
            opTxStream.Destination = src_q;
            opTxStream.Data        = wr_addr_q;
        end
    end
`else
    assign opTxStream = '0;
`endif

endmodule

// File: doc/write_controller.md
WRITE_CONTROLLER -- requirements
Module: write_controller

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 4, number of data bytes per write packet (address byte excluded).
REQ-002 SHALL have parameter WRITE_DEST, default 8'h01, Destination value that selects this block.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as listed next.
REQ-004 SHALL have port ipClk  input  1  rising-edge system clock.
REQ-005 SHALL have port ipReset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ipRxStream  input  UART_PACKET  received byte stream (Source, Destination, Length, SoP, EoP, Data[7:0], Valid).
REQ-007 SHALL have port ipTxReady  input  1  transmitter can accept a byte.
REQ-008 SHALL have port opTxStream  output  UART_PACKET  acknowledge stream.
REQ-009 SHALL have port opWrAddress  output  8  register write address.
REQ-010 SHALL have port opWrData  output  32  register write data.
REQ-011 SHALL have port opWrEnable  output  1  single-cycle write strobe.

Function
REQ-012 SHALL treat each cycle with ipRxStream.Valid=1 as one byte beat; Rx has no backpressure.
REQ-013 SHALL accept a packet only if its first beat has SoP=1 and Destination==WRITE_DEST; all other beats in IDLE are ignored.
REQ-014 SHALL take beat 0 as address and beats 1..DATA_LENGTH as data, MSB first (beat 1 -> opWrData[31:24]).
REQ-015 SHALL use states IDLE -> GET_DATA (byte counter DATA_LENGTH..1) -> WRITE -> IDLE, plus DISCARD and (with macro) ACK.
REQ-016 SHALL pulse opWrEnable high for exactly one cycle, the cycle after the last data beat (EoP=1) is sampled; opWrAddress/opWrData stable that cycle and held until the next write.
REQ-017 SHALL, on EoP before the last data beat, abort without a write and return to IDLE.
REQ-018 SHALL, if the last data beat lacks EoP, still write, then enter DISCARD and drop beats until EoP.
REQ-019 SHALL, on SoP with matching Destination while in GET_DATA, abandon the current packet and restart with that beat as the address.
REQ-020 SHALL hold the byte counter to 3 bits wide minimum and never wrap below 1.
REQ-021 SHALL drive opTxStream.Valid=0 in IDLE, GET_DATA, WRITE, DISCARD.

Reset
REQ-022 SHALL, on ipReset low, immediately set state IDLE, opWrEnable=0, opWrAddress=0, opWrData=0, all opTxStream fields 0.
REQ-023 SHALL, on reset mid-packet, discard the partial packet and issue no write.
REQ-024 SHALL leave reset synchronously to ipClk; the first accepted beat is the first cycle after ipReset is sampled high.

Configuration
REQ-025 SHALL compile the acknowledge path only when macro WRITE_CONTROLLER_ACK_EN is defined.
REQ-026 SHALL, with WRITE_CONTROLLER_ACK_EN, go WRITE -> ACK and drive opTxStream Valid=1, SoP=1, EoP=1, Length=1, Source=WRITE_DEST, Destination=captured Source, Data=written address; holding until a cycle with ipTxReady=1, then return to IDLE.
REQ-027 SHALL, with WRITE_CONTROLLER_ACK_EN, ignore all Rx beats while in ACK.
REQ-028 SHALL, without WRITE_CONTROLLER_ACK_EN, go WRITE -> IDLE and tie opTxStream to all-zero.

Structure
REQ-029 SHALL take UART_PACKET from the shared Structures package; the state enum and default WRITE_DEST constant SHALL also live there.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL check: packet Dest=01, Src=05, bytes 10,DE,AD,BE,EF (EoP on last) -> one-cycle opWrEnable, opWrAddress=8'h10, opWrData=32'hDEADBEEF.
REQ-032 SHALL check: same packet with Dest=00 -> no opWrEnable, outputs unchanged.
REQ-033 SHALL check: bytes 20,11,22 with EoP on 22 -> no write, next valid packet to 8'h21 writes correctly.
REQ-034 SHALL check: ipReset low after 3 beats -> all outputs 0, no write; following full packet writes normally.
REQ-035 SHALL check (ACK_EN): ipTxReady low 10 cycles after write -> opTxStream Valid held with Data=8'h10, Destination=8'h05; drops the cycle after ipTxReady high; Rx beats during ACK ignored.
REQ-036 SHALL check: 6-beat packet without EoP on beat 5, EoP on beat 6 -> write of beats 1-5 only, beat 6 dropped.
